// File: rtl/sbox_sched.sv
`default_nettype none
// ============================================================================
// sbox_sched : round-robin sequencer sharing one registered AES S-box between
//              the SubBytes (16-byte) and SubWord (4-byte) requesters.
// Revision   : 1.0
// ============================================================================
module sbox_sched #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_start,
  input  logic [127:0] st_in,
  output logic         st_busy,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_start,
  input  logic [31:0]  kw_in,
  output logic         kw_busy,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic [7:0]   sbox_in,
  input  logic [7:0]   sbox_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_sel_kw;
  logic          r_last_kw;
  logic [4:0]    r_cnt;
  logic [127:0]  r_st_op;
  logic [31:0]   r_kw_op;
  logic [127:0]  r_res;
  logic [SBOX_LAT:0] r_vld;
  logic [3:0]    r_idx [0:SBOX_LAT];

  logic          w_st_acc;
  logic          w_kw_acc;
  logic          w_st_req;
  logic          w_kw_req;
  logic          w_grant;
  logic          w_grant_kw;
  logic [7:0]    w_byte0;
  logic [7:0]    w_st_byte;
  logic [7:0]    w_kw_byte;
  logic [4:0]    w_n;
  logic [3:0]    w_cap_idx;
  logic [6:0]    w_cap_base;
  logic          w_cap;
  logic          w_last_cap;

  assign w_st_acc   = st_start & ~st_busy;
  assign w_kw_acc   = kw_start & ~kw_busy;
  // A channel in its done cycle is still busy but must not be granted again
  assign w_st_req   = w_st_acc | (st_busy & ~st_done);
  assign w_kw_req   = w_kw_acc | (kw_busy & ~kw_done);
  assign w_grant    = w_st_req | w_kw_req;
  assign w_grant_kw = w_kw_req & (~w_st_req | ~r_last_kw);

  // Byte 0 bypasses the operand register when the start is accepted this edge
  assign w_byte0    = w_grant_kw ? (w_kw_acc ? kw_in[31:24]  : r_kw_op[31:24])
                                 : (w_st_acc ? st_in[127:120] : r_st_op[127:120]);
  assign w_st_byte  = r_st_op[7'd127 - {r_cnt[3:0], 3'b000} -: 8];
  assign w_kw_byte  = r_kw_op[5'd31 - {r_cnt[1:0], 3'b000} -: 8];
  assign w_n        = r_sel_kw ? 5'd4 : 5'd16;

  assign w_cap      = r_vld[SBOX_LAT];
  assign w_cap_idx  = r_idx[SBOX_LAT];
  assign w_cap_base = 7'd127 - {w_cap_idx, 3'b000};
  assign w_last_cap = w_cap && (w_cap_idx == (r_sel_kw ? 4'd3 : 4'd15));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel_kw  <= 1'b0;
      r_last_kw <= 1'b0;
      r_cnt     <= 5'd0;
      r_st_op   <= '0;
      r_kw_op   <= '0;
      r_res     <= '0;
      r_vld     <= '0;
      for (int k = 0; k <= SBOX_LAT; k++) r_idx[k] <= 4'd0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_out    <= '0;
      kw_busy   <= 1'b0;
      kw_done   <= 1'b0;
      kw_out    <= '0;
      sbox_in   <= 8'h00;
    end else begin
      st_done <= 1'b0;
      kw_done <= 1'b0;

      if (w_st_acc) begin
        r_st_op <= st_in;
        st_busy <= 1'b1;
      end else if (st_done) begin
        st_busy <= 1'b0;
      end

      if (w_kw_acc) begin
        r_kw_op <= kw_in;
        kw_busy <= 1'b1;
      end else if (kw_done) begin
        kw_busy <= 1'b0;
      end

      // In-flight tracking: stage 0 travels with sbox_in, stage LAT meets sbox_out
      r_vld[0] <= 1'b0;
      r_vld[SBOX_LAT:1] <= r_vld[SBOX_LAT-1:0];
      for (int k = 1; k <= SBOX_LAT; k++) r_idx[k] <= r_idx[k-1];

      if (w_cap) r_res[w_cap_base -: 8] <= sbox_out;

      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel_kw  <= w_grant_kw;
            r_last_kw <= w_grant_kw;
            sbox_in   <= w_byte0;
            r_vld[0]  <= 1'b1;
            r_idx[0]  <= 4'd0;
            r_cnt     <= 5'd1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_cnt == w_n) begin
            sbox_in <= 8'h00;
            r_state <= S_DRAIN;
          end else begin
            sbox_in  <= r_sel_kw ? w_kw_byte : w_st_byte;
            r_vld[0] <= 1'b1;
            r_idx[0] <= r_cnt[3:0];
            r_cnt    <= r_cnt + 5'd1;
          end
        end
        S_DRAIN: begin
          // The last byte always sits in the low bits, so merge it on the fly
          if (w_last_cap) begin
            if (r_sel_kw) begin
              kw_done <= 1'b1;
              kw_out  <= {r_res[127:104], sbox_out};
            end else begin
              st_done <= 1'b1;
              st_out  <= {r_res[127:8], sbox_out};
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sbox_sched.sv
`default_nettype none
// ============================================================================
// tb_sbox_sched : directed vector bench for sbox_sched at SBOX_LAT 1 and 3.
// Revision      : 1.0
// ============================================================================
module tb_sbox_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         st_start, kw_start;
  logic [127:0] st_in;
  logic [31:0]  kw_in;
  logic         st_busy, st_done, kw_busy, kw_done;
  logic [127:0] st_out;
  logic [31:0]  kw_out;
  logic [7:0]   sbox_in, sbox_out;

  logic         st_start3, kw_start3;
  logic [127:0] st_in3;
  logic [31:0]  kw_in3;
  logic         st_busy3, st_done3, kw_busy3, kw_done3;
  logic [127:0] st_out3;
  logic [31:0]  kw_out3;
  logic [7:0]   sbox_in3, sbox_out3;

  sbox_sched #(.SBOX_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .st_start(st_start), .st_in(st_in), .st_busy(st_busy), .st_done(st_done), .st_out(st_out),
    .kw_start(kw_start), .kw_in(kw_in), .kw_busy(kw_busy), .kw_done(kw_done), .kw_out(kw_out),
    .sbox_in(sbox_in), .sbox_out(sbox_out)
  );

  sbox_sched #(.SBOX_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .st_start(st_start3), .st_in(st_in3), .st_busy(st_busy3), .st_done(st_done3), .st_out(st_out3),
    .kw_start(kw_start3), .kw_in(kw_in3), .kw_busy(kw_busy3), .kw_done(kw_done3), .kw_out(kw_out3),
    .sbox_in(sbox_in3), .sbox_out(sbox_out3)
  );

  // AES forward S-box, row 0 in the top bits
  logic [2047:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_tab[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  logic [7:0] pipe1;
  logic [7:0] pipe3 [0:2];
  always @(posedge clk) begin
    pipe1    <= sb(sbox_in);
    pipe3[0] <= sb(sbox_in3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign sbox_out  = pipe1;
  assign sbox_out3 = pipe3[2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] seq [0:19];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    st_start = 0; kw_start = 0; st_in = '0; kw_in = '0;
    st_start3 = 0; kw_start3 = 0; st_in3 = '0; kw_in3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One job on the LAT=1 instance; edge 0 is the edge that samples the start
  task automatic job(input string name, input logic is_kw, input logic [127:0] din,
                     input logic [127:0] exp, input int exp_e);
    int done_at, n_done;
    bit busy_ok, hold_ok;
    logic [127:0] prev, cur;
    done_at = -1; n_done = 0; busy_ok = 1; hold_ok = 1;
    prev = is_kw ? {96'h0, kw_out} : st_out;
    cur  = prev;
    @(negedge clk);
    if (is_kw) begin kw_in = din[31:0]; kw_start = 1'b1; end
    else       begin st_in = din;       st_start = 1'b1; end
    @(posedge clk); #1;
    kw_start = 1'b0; st_start = 1'b0;
    for (int e = 0; e <= exp_e + 4; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (e < 20) seq[e] = sbox_in;
      cur = is_kw ? {96'h0, kw_out} : st_out;
      if (is_kw ? kw_done : st_done) begin
        n_done++;
        if (done_at < 0) done_at = e;
      end
      if ((e <= exp_e) != (is_kw ? kw_busy : st_busy)) busy_ok = 0;
      if (e < exp_e && cur !== prev) hold_ok = 0;
    end
    check_int({name, "_done_edge"}, done_at, exp_e);
    check_int({name, "_done_count"}, n_done, 1);
    check_int({name, "_busy_window"}, int'(busy_ok), 1);
    check_int({name, "_hold"}, int'(hold_ok), 1);
    check({name, "_out"}, cur, exp);
  endtask

  typedef struct {
    logic         is_kw;
    logic [127:0] din;
    logic [127:0] exp;
    int           edges;
  } vec_t;

  vec_t tab [0:5];

  initial begin
    int kd, sd, n_done, done_at;
    bit busy_ok;

    tab[0] = '{1'b1, 128'h00010253, 128'h637c77ed, 5};
    tab[1] = '{1'b0, 128'h0, {16{8'h63}}, 17};
    tab[2] = '{1'b0, {16{8'hff}}, {16{8'h16}}, 17};
    tab[3] = '{1'b1, 128'h53535353, 128'hedededed, 5};
    tab[4] = '{1'b1, 128'h10203040, 128'hcab70409, 5};
    tab[5] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f,
               128'h637c777bf26b6fc53001672bfed7ab76, 17};

    do_reset();
    #1;
    check("reset_ctrl", {st_busy, st_done, kw_busy, kw_done, sbox_in}, '0);
    check("reset_st_out", st_out, '0);
    check("reset_kw_out", {96'h0, kw_out}, '0);
    check("reset_lat3", {st_busy3, kw_busy3, sbox_in3, kw_out3}, '0);

    for (int i = 0; i < 6; i++) begin
      job($sformatf("vec%0d", i), tab[i].is_kw, tab[i].din, tab[i].exp, tab[i].edges);
      if (i == 0)
        check("kw_sbox_in_seq", {seq[0], seq[1], seq[2], seq[3], seq[4]}, 40'h0001025300);
    end

    // Simultaneous starts straight after reset: key word wins the first tie
    do_reset();
    @(negedge clk);
    kw_in = 32'h53535353; kw_start = 1'b1;
    st_in = 128'h000102030405060708090a0b0c0d0e0f; st_start = 1'b1;
    @(posedge clk); #1;
    kw_start = 1'b0; st_start = 1'b0;
    kd = -1; sd = -1;
    for (int e = 0; e <= 30; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (kw_done && kd < 0) kd = e;
      if (st_done && sd < 0) sd = e;
    end
    check_int("tie_kw_done_edge", kd, 5);
    check_int("tie_st_done_edge", sd, 23);
    check("tie_kw_out", {96'h0, kw_out}, 128'hedededed);
    check("tie_st_out", st_out, 128'h637c777bf26b6fc53001672bfed7ab76);

    // Starts while busy and during the done cycle must both be ignored
    @(negedge clk);
    st_in = '0; st_start = 1'b1;
    @(posedge clk); #1;
    st_start = 1'b0;
    n_done = 0; done_at = -1; busy_ok = 1;
    for (int e = 0; e <= 40; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (st_done) begin
        n_done++;
        if (done_at < 0) done_at = e;
      end
      if (e >= 20 && st_busy) busy_ok = 0;
      if (e == 3 || e == 17) begin st_in = {16{8'hff}}; st_start = 1'b1; end
      else st_start = 1'b0;
    end
    check_int("busy_start_done_edge", done_at, 17);
    check_int("busy_start_done_count", n_done, 1);
    check_int("busy_start_idle_after", int'(busy_ok), 1);
    check("busy_start_out", st_out, {16{8'h63}});

    // Reset mid-job at byte 7
    @(negedge clk);
    st_in = 128'h000102030405060708090a0b0c0d0e0f; st_start = 1'b1;
    @(posedge clk); #1;
    st_start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("midrst_byte7", {120'h0, sbox_in}, 128'h07);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {st_busy, st_done, kw_busy, kw_done, sbox_in}, '0);
    check("midrst_st_out", st_out, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (st_done || st_busy) n_done++;
    end
    check_int("midrst_no_done", n_done, 0);
    job("post_rst_kw", 1'b1, 128'h10203040, 128'hcab70409, 5);

    // SBOX_LAT = 3 key-word rerun
    @(negedge clk);
    kw_in3 = 32'h00010253; kw_start3 = 1'b1;
    @(posedge clk); #1;
    kw_start3 = 1'b0;
    n_done = 0; done_at = -1;
    for (int e = 0; e <= 15; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (kw_done3) begin
        n_done++;
        if (done_at < 0) done_at = e;
      end
    end
    check_int("lat3_done_edge", done_at, 7);
    check_int("lat3_done_count", n_done, 1);
    check("lat3_kw_out", {96'h0, kw_out3}, 128'h637c77ed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
